// File: rtl/region_blitter.sv
// region_blitter
// Streams pixels for a set of horizontal screen bands (regions) from an
// external synchronous ROM into a pixel-write interface. A job is either one
// full-screen pass or a pass over every region selected in region_mask, drawn
// in ascending region index order. One ROM address is issued per cycle and the
// matching pixel is written one cycle later, when the ROM data is available.
//
// Ports
//   clock        sole clock, rising edge
//   resetn       asynchronous active-low reset
//   start        begin a job (only honoured in IDLE)
//   full_screen  sampled with start; 1 = single full-screen job
//   region_mask  sampled with start; bit i = draw region i
//   abort        end the job at the next edge (ignored in IDLE/DONE)
//   rom_data     pixel from the ROM, one cycle after rom_addr/rom_sel
//   rom_addr     ROM address, 0..limit-1 within a region
//   rom_sel      region being fetched (0 for full-screen)
//   writeEn      pixel write strobe
//   x, y         pixel column and row of the current write
//   colour       pixel colour of the current write
//   busy         a job is in progress
//   done         one-cycle pulse at the end of a job
`timescale 1ns/1ps
module region_blitter #(
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int REGION_H    = 50,
  parameter int NUM_REGIONS = 4,
  parameter int Y_BASE      = 20,
  parameter int Y_PITCH     = 55,
  parameter int COLOUR_W    = 3,
  localparam int X_W    = $clog2(SCREEN_W),
  localparam int Y_W    = $clog2(SCREEN_H),
  localparam int ADDR_W = $clog2(SCREEN_W * SCREEN_H),
  localparam int SEL_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   full_screen,
  input  logic [NUM_REGIONS-1:0] region_mask,
  input  logic                   abort,
  input  logic [COLOUR_W-1:0]    rom_data,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [SEL_W-1:0]       rom_sel,
  output logic                   writeEn,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COLOUR_W-1:0]    colour,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_W-1:0] LAST_FULL   = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [ADDR_W-1:0] LAST_REGION = ADDR_W'(SCREEN_W * REGION_H - 1);
  localparam logic [X_W-1:0]    COL_LAST    = X_W'(SCREEN_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    FETCH  = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic                     armed_r;
  logic                     full_r;
  logic [NUM_REGIONS-1:0]   mask_r;
  logic [ADDR_W-1:0]        addr_r;
  logic [ADDR_W-1:0]        last_r;
  logic [X_W-1:0]           col_r;
  logic [Y_W-1:0]           row_r;
  logic [Y_W-1:0]           origin_r;
  logic [SEL_W-1:0]         sel_r;
  logic                     wr_en_r;
  logic [X_W-1:0]           x_r;
  logic [Y_W-1:0]           y_r;
  logic [COLOUR_W-1:0]      colour_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     found_s;
  logic [SEL_W-1:0]         sel_idx_s;
  logic [Y_W-1:0]           origin_s;

  // Lowest pending region in the latched mask and the top row of that region.
  always_comb begin
    found_s   = 1'b0;
    sel_idx_s = '0;
    // Scan downwards so the lowest set bit is the one that sticks.
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (mask_r[i]) begin
        found_s   = 1'b1;
        sel_idx_s = SEL_W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
    origin_s = Y_W'(Y_BASE + Y_PITCH * int'(sel_idx_s));
  end

  // Job state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decision; abort wins over every other transition while active.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        // armed_r holds off the very first edge after reset release.
        if (start && armed_r) begin
          state_next_s = SELECT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SELECT: begin
        if (abort) begin
          state_next_s = DONE;
        end else if (full_r || found_s) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = DONE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_next_s = DONE;
        end else if (addr_r == last_r) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = FETCH;
        end
      end
      FLUSH: begin
        if (abort) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SELECT;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Job context, address/column/row counters and the one-stage pixel pipeline.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      armed_r  <= 1'b0;
      full_r   <= 1'b0;
      mask_r   <= '0;
      addr_r   <= '0;
      last_r   <= '0;
      col_r    <= '0;
      row_r    <= '0;
      origin_r <= '0;
      sel_r    <= '0;
      wr_en_r  <= 1'b0;
      x_r      <= '0;
      y_r      <= '0;
      colour_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      armed_r <= 1'b1;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);

      // The address issued this cycle becomes next cycle's write; the ROM
      // delivers its data in that same next cycle.
      wr_en_r <= (state_r == FETCH);
      if (state_r == FETCH) begin
        x_r <= col_r;
        y_r <= origin_r + row_r;
      end
      if (wr_en_r) begin
        colour_r <= rom_data;
      end

      case (state_r)
        IDLE: begin
          if (state_next_s == SELECT) begin
            full_r <= full_screen;
            // A full-screen job ignores the mask, so the SELECT after the
            // single pass finds nothing left and finishes.
            mask_r <= full_screen ? '0 : region_mask;
          end
        end
        SELECT: begin
          if (state_next_s == FETCH) begin
            addr_r <= '0;
            col_r  <= '0;
            row_r  <= '0;
            if (full_r) begin
              full_r   <= 1'b0;
              last_r   <= LAST_FULL;
              origin_r <= '0;
              sel_r    <= '0;
            end else begin
              last_r   <= LAST_REGION;
              origin_r <= origin_s;
              sel_r    <= sel_idx_s;
              mask_r   <= mask_r & ~(NUM_REGIONS'(1) << sel_idx_s);
            end
          end
        end
        FETCH: begin
          if (state_next_s == FETCH) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (col_r == COL_LAST) begin
              col_r <= '0;
              row_r <= row_r + Y_W'(1);
            end else begin
              col_r <= col_r + X_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rom_addr = addr_r;
  assign rom_sel  = sel_r;
  assign writeEn  = wr_en_r;
  assign x        = x_r;
  assign y        = y_r;
  // The ROM data arrives in the write cycle itself, so it is passed through
  // while writing and the last written colour is held otherwise.
  assign colour   = wr_en_r ? rom_data : colour_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_region_blitter.sv
// tb_region_blitter
// Drives three region_blitter instances (default geometry, a tiny 4-wide
// single-region geometry and a small geometry whose y wraps) one at a time,
// and compares every observed pixel write and done pulse against a reference
// built from screen geometry with plain division/modulo.
`timescale 1ns/1ps
module tb_region_blitter;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } pix_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  int         inst = 0;
  logic       start = 1'b0;
  logic       full_screen = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] mask = 4'd0;
  logic [2:0] salt = 3'd0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  pix_t wq[$];
  int   dq[$];
  pix_t ep[$];
  int   exp_done;
  pix_t mon_p;

  always #5 clock = ~clock;

  // Instance A: default geometry
  logic [16:0] addr_a;
  logic [1:0]  sel_a;
  logic        we_a, busy_a, done_a;
  logic [8:0]  x_a;
  logic [7:0]  y_a;
  logic [2:0]  col_a, rom_a;
  region_blitter dut_a (
    .clock(clock), .resetn(resetn), .start(start && (inst == 0)),
    .full_screen(full_screen), .region_mask(mask), .abort(abort && (inst == 0)),
    .rom_data(rom_a), .rom_addr(addr_a), .rom_sel(sel_a), .writeEn(we_a),
    .x(x_a), .y(y_a), .colour(col_a), .busy(busy_a), .done(done_a));

  // Instance B: 4 columns, one 2-row region
  logic [9:0] addr_b;
  logic       sel_b;
  logic       we_b, busy_b, done_b;
  logic [1:0] x_b;
  logic [7:0] y_b;
  logic [2:0] col_b, rom_b;
  region_blitter #(.SCREEN_W(4), .REGION_H(2), .NUM_REGIONS(1)) dut_b (
    .clock(clock), .resetn(resetn), .start(start && (inst == 1)),
    .full_screen(full_screen), .region_mask(mask[0]), .abort(abort && (inst == 1)),
    .rom_data(rom_b), .rom_addr(addr_b), .rom_sel(sel_b), .writeEn(we_b),
    .x(x_b), .y(y_b), .colour(col_b), .busy(busy_b), .done(done_b));

  // Instance C: 8x16 screen, four 3-row regions, last region wraps in y
  logic [6:0] addr_c;
  logic [1:0] sel_c;
  logic       we_c, busy_c, done_c;
  logic [2:0] x_c;
  logic [3:0] y_c;
  logic [2:0] col_c, rom_c;
  region_blitter #(.SCREEN_W(8), .SCREEN_H(16), .REGION_H(3), .NUM_REGIONS(4),
                   .Y_BASE(2), .Y_PITCH(5)) dut_c (
    .clock(clock), .resetn(resetn), .start(start && (inst == 2)),
    .full_screen(full_screen), .region_mask(mask), .abort(abort && (inst == 2)),
    .rom_data(rom_c), .rom_addr(addr_c), .rom_sel(sel_c), .writeEn(we_c),
    .x(x_c), .y(y_c), .colour(col_c), .busy(busy_c), .done(done_c));

  // Synchronous ROMs with one cycle of latency
  always @(posedge clock) begin
    rom_a <= (addr_a[2:0] + 3'(sel_a) * 3'd3) ^ salt;
    rom_b <= (addr_b[2:0] + 3'(sel_b) * 3'd3) ^ salt;
    rom_c <= (addr_c[2:0] + 3'(sel_c) * 3'd3) ^ salt;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Record every write and done pulse away from the active edge
  always @(negedge clock) begin
    if (we_a) begin
      mon_p.x = int'(x_a); mon_p.y = int'(y_a); mon_p.c = int'(col_a); mon_p.t = cyc;
      wq.push_back(mon_p);
    end else if (we_b) begin
      mon_p.x = int'(x_b); mon_p.y = int'(y_b); mon_p.c = int'(col_b); mon_p.t = cyc;
      wq.push_back(mon_p);
    end else if (we_c) begin
      mon_p.x = int'(x_c); mon_p.y = int'(y_c); mon_p.c = int'(col_c); mon_p.t = cyc;
      wq.push_back(mon_p);
    end
    if (done_a || done_b || done_c) dq.push_back(cyc);
  end

  task automatic get_params(input int k, output int w, output int h, output int rh,
                            output int nr, output int yb, output int yp, output int hy);
    case (k)
      0:       begin w = 320; h = 240; rh = 50; nr = 4; yb = 20; yp = 55; hy = 256; end
      1:       begin w = 4;   h = 240; rh = 2;  nr = 1; yb = 20; yp = 55; hy = 256; end
      default: begin w = 8;   h = 16;  rh = 3;  nr = 4; yb = 2;  yp = 5;  hy = 16;  end
    endcase
  endtask

  // Reference: job cycle 1 is the first SELECT; each region costs SELECT +
  // limit FETCH cycles + FLUSH; a fetch in cycle f is written in cycle f+1;
  // abort in cycle k keeps fetches up to k and puts DONE in cycle k+1.
  task automatic build_model(input int k, input bit full, input logic [3:0] m,
                             input int abort_k, input logic [2:0] sl);
    int w, h, rh, nr, yb, yp, hy, s, f;
    int orgs[$], sels[$], lens[$];
    pix_t p;
    get_params(k, w, h, rh, nr, yb, yp, hy);
    ep.delete();
    if (full) begin
      orgs.push_back(0); sels.push_back(0); lens.push_back(w * h);
    end else begin
      for (int i = 0; i < nr; i++) begin
        if (m[i]) begin
          orgs.push_back(yb + i * yp); sels.push_back(i); lens.push_back(w * rh);
        end
      end
    end
    s = 1;
    for (int r = 0; r < lens.size(); r++) begin
      for (int a = 0; a < lens[r]; a++) begin
        f = s + 1 + a;
        if (abort_k == 0 || f <= abort_k) begin
          p.x = a % w;
          p.y = (orgs[r] + a / w) % hy;
          p.c = (((a % 8) + 3 * sels[r]) % 8) ^ int'(sl);
          p.t = f + 1;
          ep.push_back(p);
        end
      end
      s = s + lens[r] + 2;
    end
    exp_done = (abort_k != 0 && abort_k <= s) ? abort_k + 1 : s + 1;
  endtask

  // Run one job on instance k and compare writes, done pulse and busy
  task automatic run_job(input string name, input int k, input bit full,
                         input logic [3:0] m, input int abort_k, input bit poke);
    int n0, j, nmis, gd;
    logic [2:0] sl;
    sl = 3'($urandom_range(0, 7));
    salt = sl;
    build_model(k, full, m, abort_k, sl);
    wq.delete();
    dq.delete();
    inst = k; full_screen = full; mask = m; start = 1'b1;
    @(posedge clock); #1;
    n0 = cyc;
    start = 1'b0; full_screen = 1'b0; mask = 4'($urandom_range(0, 15));
    j = 1;
    while (j <= exp_done + 2) begin
      abort = (abort_k == j);
      start = poke && (j == 3) && (exp_done > 4);
      @(posedge clock); #1;
      j++;
    end
    abort = 1'b0; start = 1'b0;

    checks++;
    if (wq.size() != ep.size()) begin
      errors++;
      $display("FAIL %s write_count got %0d want %0d", name, wq.size(), ep.size());
    end
    nmis = -1;
    for (int i = 0; i < wq.size() && i < ep.size(); i++) begin
      if (wq[i].x != ep[i].x || wq[i].y != ep[i].y || wq[i].c != ep[i].c ||
          (wq[i].t - n0 + 1) != ep[i].t) begin
        nmis = i;
        break;
      end
    end
    checks++;
    if (nmis >= 0) begin
      errors++;
      $display("FAIL %s pixel[%0d] got x=%0d y=%0d c=%0d cyc=%0d want x=%0d y=%0d c=%0d cyc=%0d",
               name, nmis, wq[nmis].x, wq[nmis].y, wq[nmis].c, wq[nmis].t - n0 + 1,
               ep[nmis].x, ep[nmis].y, ep[nmis].c, ep[nmis].t);
    end
    gd = (dq.size() > 0) ? dq[0] - n0 + 1 : -1;
    checks++;
    if (dq.size() != 1 || gd != exp_done) begin
      errors++;
      $display("FAIL %s done got %0d pulses first at %0d want 1 pulse at %0d",
               name, dq.size(), gd, exp_done);
    end
    checks++;
    if ((busy_a | busy_b | busy_c) !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after got %b want 0", name, busy_a | busy_b | busy_c);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({we_a, x_a, y_a, col_a, addr_a, sel_a, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL reset_a got %h want 0", {we_a, x_a, y_a, col_a, addr_a, sel_a, busy_a, done_a});
    end
    checks++;
    if ({we_b, x_b, y_b, col_b, addr_b, sel_b, busy_b, done_b} !== '0) begin
      errors++;
      $display("FAIL reset_b got %h want 0", {we_b, x_b, y_b, col_b, addr_b, sel_b, busy_b, done_b});
    end
    checks++;
    if ({we_c, x_c, y_c, col_c, addr_c, sel_c, busy_c, done_c} !== '0) begin
      errors++;
      $display("FAIL reset_c got %h want 0", {we_c, x_c, y_c, col_c, addr_c, sel_c, busy_c, done_c});
    end
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_empty();
    run_job("empty_mask", 0, 1'b0, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_region0();
    run_job("region0", 0, 1'b0, 4'b0001, 0, 1'b0);
    checks++;
    if (wq.size() == 0 || wq[0].x != 0 || wq[0].y != 20) begin
      errors++;
      $display("FAIL region0_first got n=%0d want (0,20)", wq.size());
    end
    checks++;
    if (wq.size() == 0 || wq[wq.size()-1].x != 319 || wq[wq.size()-1].y != 69) begin
      errors++;
      $display("FAIL region0_last got n=%0d want (319,69)", wq.size());
    end
  endtask

  task automatic test_regions_1_3();
    run_job("regions_1_3", 0, 1'b0, 4'b1010, 0, 1'b1);
    checks++;
    if (wq.size() != 32000 || wq[0].y != 75 || wq[15999].y != 124 ||
        wq[16000].y != 185 || wq[31999].y != 234) begin
      errors++;
      $display("FAIL regions_1_3_rows got n=%0d want 32000 rows 75..124,185..234", wq.size());
    end
  endtask

  task automatic test_abort();
    // FETCH cycle 100 of region 0 is job cycle 101
    run_job("abort_100", 0, 1'b0, 4'b0001, 101, 1'b0);
    checks++;
    if (wq.size() != 100) begin
      errors++;
      $display("FAIL abort_count got %0d want 100", wq.size());
    end
    run_job("after_abort", 0, 1'b0, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    inst = 0; mask = 4'b0001; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (30) @(posedge clock);
    #3;
    checks++;
    if (we_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_active got %b want 1", we_a);
    end
    resetn = 1'b0;
    #0.5;
    checks++;
    if ({we_a, x_a, y_a, col_a, addr_a, sel_a, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h want 0", {we_a, x_a, y_a, col_a, addr_a, sel_a, busy_a, done_a});
    end
    #0.5;
    resetn = 1'b1;
    wq.delete();
    repeat (40) @(posedge clock);
    #1;
    checks++;
    if (wq.size() != 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet got writes=%0d busy=%b want 0 0", wq.size(), busy_a);
    end
    // Start held across reset: first job must be in SELECT two edges later
    inst = 0; mask = 4'b0000; start = 1'b1;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL release_edge1 busy got %b want 0", busy_a);
    end
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL release_edge2 busy got %b want 1", busy_a);
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_tiny();
    run_job("tiny", 1, 1'b0, 4'b0001, 0, 1'b0);
    checks++;
    if (wq.size() != 8 || wq[7].x != 3 || wq[7].y != 21) begin
      errors++;
      $display("FAIL tiny_last got n=%0d want 8 ending (3,21)", wq.size());
    end
  endtask

  task automatic test_full_screen();
    run_job("full_b", 1, 1'b1, 4'b0000, 0, 1'b1);
    checks++;
    if (wq.size() != 960 || wq[0].x != 0 || wq[0].y != 0 || wq[959].x != 3 || wq[959].y != 239) begin
      errors++;
      $display("FAIL full_b_ends got n=%0d want 960 from (0,0) to (3,239)", wq.size());
    end
    run_job("full_c", 2, 1'b1, 4'b1111, 0, 1'b0);
  endtask

  task automatic test_y_wrap();
    run_job("wrap_c", 2, 1'b0, 4'b1000, 0, 1'b0);
    checks++;
    if (wq.size() == 0 || wq[0].y != 1) begin
      errors++;
      $display("FAIL wrap_first_y got n=%0d want y=1", wq.size());
    end
  endtask

  task automatic test_random();
    bit full;
    logic [3:0] m;
    int ak;
    for (int it = 0; it < 16; it++) begin
      full = ($urandom_range(0, 5) == 0);
      m = 4'($urandom_range(0, 15));
      ak = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 70) : 0;
      run_job($sformatf("rand%0d", it), 2, full, m, ak, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_region0();
    test_regions_1_3();
    test_abort();
    test_reset_mid();
    test_tiny();
    test_full_screen();
    test_y_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
